// File: rtl/wd_service_ctrl.sv
// Watchdog service controller: opens a service window after SVCMIN cycles and issues one
// service pulse once every required heartbeat source has checked in; latches miss/config/overflow faults.
module wd_service_ctrl #(
   parameter int NHB = 4
) (
   input  logic           CLK,
   input  logic           WDRST,
   input  logic           ENABLE,
   input  logic [NHB-1:0] HBEAT,
   input  logic [NHB-1:0] HBMASK,
   input  logic [15:0]    SVCMIN,
   input  logic [15:0]    SVCMAX,
   input  logic           FWOVR,
   output logic           WDSRVC,
   output logic           SVCERR,
   output logic           CFGERR,
   output logic           FAULT,
   output logic [2:0]     STATE,
   output logic [7:0]     SVCCNT
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLOSED  = 3'd1,
      ST_OPEN    = 3'd2,
      ST_MISSED  = 3'd3,
      ST_FAULTED = 3'd4
   } state_e;

   localparam logic [NHB-1:0] HB_NONE = {NHB{1'b0}};

   state_e         state_q, state_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [NHB-1:0] hb_seen_q, hb_seen_d;
   logic           wdsrvc_q, wdsrvc_d;
   logic           svcerr_q, svcerr_d;
   logic           cfgerr_q, cfgerr_d;
   logic           fault_q, fault_d;
   logic [7:0]     svccnt_q, svccnt_d;

   logic [15:0]    cnt_inc_s;
   logic [NHB-1:0] hb_all_s;
   logic           ready_s;

   // Heartbeats arriving on the deciding edge count toward readiness.
   assign cnt_inc_s = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
   assign hb_all_s  = hb_seen_q | HBEAT;
   assign ready_s   = ((hb_all_s & HBMASK) == HBMASK);

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (WDRST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 16'd0;
         hb_seen_q <= HB_NONE;
         wdsrvc_q  <= 1'b0;
         svcerr_q  <= 1'b0;
         cfgerr_q  <= 1'b0;
         fault_q   <= 1'b0;
         svccnt_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hb_seen_q <= hb_seen_d;
         wdsrvc_q  <= wdsrvc_d;
         svcerr_q  <= svcerr_d;
         cfgerr_q  <= cfgerr_d;
         fault_q   <= fault_d;
         svccnt_q  <= svccnt_d;
      end
   end

   // Next-state logic; overflow outranks every other decision outside IDLE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hb_seen_d = hb_seen_q;
      wdsrvc_d  = 1'b0;
      svcerr_d  = svcerr_q;
      cfgerr_d  = cfgerr_q;
      fault_d   = fault_q;
      svccnt_d  = svccnt_q;
      if ((state_q != ST_IDLE) && FWOVR) begin
         state_d = ST_FAULTED;
         fault_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d     = 16'd0;
               hb_seen_d = HB_NONE;
               if (ENABLE && (SVCMIN < SVCMAX)) begin
                  state_d = ST_CLOSED;
               end else if (ENABLE) begin
                  cfgerr_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CLOSED: begin
               if (!ENABLE) begin
                  state_d   = ST_IDLE;
                  cnt_d     = 16'd0;
                  hb_seen_d = HB_NONE;
               end else begin
                  cnt_d     = cnt_inc_s;
                  hb_seen_d = hb_all_s;
                  if (cnt_q == SVCMIN) begin
                     state_d = ST_OPEN;
                  end else begin
                     state_d = ST_CLOSED;
                  end
               end
            end
            ST_OPEN: begin
               if (!ENABLE) begin
                  state_d   = ST_IDLE;
                  cnt_d     = 16'd0;
                  hb_seen_d = HB_NONE;
               end else if (ready_s) begin
                  wdsrvc_d  = 1'b1;
                  svccnt_d  = svccnt_q + 8'd1;
                  cnt_d     = 16'd0;
                  hb_seen_d = HB_NONE;
                  state_d   = ST_CLOSED;
               end else if (cnt_q == SVCMAX) begin
                  state_d  = ST_MISSED;
                  svcerr_d = 1'b1;
                  cnt_d    = cnt_inc_s;
               end else begin
                  cnt_d     = cnt_inc_s;
                  hb_seen_d = hb_all_s;
               end
            end
            ST_MISSED: begin
               cnt_d = cnt_inc_s;
            end
            ST_FAULTED: begin
               state_d = ST_FAULTED;
            end
            default: begin
               state_d   = ST_IDLE;
               cnt_d     = 16'd0;
               hb_seen_d = HB_NONE;
            end
         endcase
      end
   end

   assign WDSRVC = wdsrvc_q;
   assign SVCERR = svcerr_q;
   assign CFGERR = cfgerr_q;
   assign FAULT  = fault_q;
   assign STATE  = state_q;
   assign SVCCNT = svccnt_q;

endmodule
